pid_alu_seq: RTL and testbench

Control sequencer that drives the shared PID ALU's select/modifier lines and captures its `dst` result into the controller's working registers. On each `go` it runs one full control cycle:
- sweeps six IR channels through the A2D (start/complete handshake) and forms a weighted error sum;
- saturates the sum to a 12-bit error and updates the integrator on a decimated schedule;
- computes the P and I products;
- produces the saturated right and left drive values.

It sits between the A2D interface and the motor drive registers. It is the initiator of the ALU's control interface.

---
 rtl/pid_alu_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_pid_alu_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pid_alu_seq
//  Description : Control sequencer for the shared PID ALU. One control cycle
//                per accepted `go`: six-channel A2D sweep into a weighted
//                error sum, error saturation, decimated integrator update,
//                P/I products, and saturated right/left drive values.
//  Revision    : 1.0  initial release
// ============================================================================
module pid_alu_seq #(
  parameter int SETTLE  = 4,
  parameter int INT_DEC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        cnv_cmplt,
  input  logic [15:0] dst,
  output logic [2:0]  chnnl,
  output logic        strt_cnv,
  output logic [2:0]  src1sel,
  output logic [2:0]  src0sel,
  output logic        multiply,
  output logic        sub,
  output logic        mult2,
  output logic        mult4,
  output logic        saturate,
  output logic [15:0] Accum,
  output logic [15:0] Pcomp,
  output logic [11:0] Error,
  output logic [11:0] Intgrl,
  output logic [11:0] Icomp,
  output logic [11:0] rht_reg,
  output logic [11:0] lft_reg,
  output logic        busy,
  output logic        done
);

  // Counter widths; a parameter of 1 still needs a 1-bit counter.
  localparam int SC_W = (SETTLE  > 1) ? $clog2(SETTLE)  : 1;
  localparam int IC_W = (INT_DEC > 1) ? $clog2(INT_DEC) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);
  localparam logic [IC_W-1:0] INT_LAST    = IC_W'(INT_DEC - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_SETTLE = 4'd1,
    S_CONV   = 4'd2,
    S_WAIT   = 4'd3,
    S_ACCUM  = 4'd4,
    S_ERR    = 4'd5,
    S_INTG   = 4'd6,
    S_ICOMP  = 4'd7,
    S_PCOMP  = 4'd8,
    S_RHT1   = 4'd9,
    S_RHT2   = 4'd10,
    S_LFT1   = 4'd11,
    S_LFT2   = 4'd12
  } state_t;

  state_t            state_q;
  logic [2:0]        ch_q;
  logic [SC_W-1:0]   set_cnt_q;
  logic [IC_W-1:0]   int_cnt_q;
  logic [15:0]       accum_q;
  logic [15:0]       pcomp_q;
  logic [11:0]       error_q;
  logic [11:0]       intgrl_q;
  logic [11:0]       icomp_q;
  logic [11:0]       rht_q;
  logic [11:0]       lft_q;
  logic              done_q;

  // Sequencer: state advance and capture of the ALU result into working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      set_cnt_q <= '0;
      int_cnt_q <= '0;
      accum_q   <= '0;
      pcomp_q   <= '0;
      error_q   <= '0;
      intgrl_q  <= '0;
      icomp_q   <= '0;
      rht_q     <= '0;
      lft_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            accum_q   <= '0;
            ch_q      <= 3'd0;
            set_cnt_q <= '0;
            state_q   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (set_cnt_q == SETTLE_LAST) begin
            set_cnt_q <= '0;
            state_q   <= S_CONV;
          end else begin
            set_cnt_q <= set_cnt_q + 1'b1;
          end
        end
        S_CONV: state_q <= S_WAIT;
        S_WAIT: begin
          // Only a completion seen while waiting counts; earlier pulses are lost.
          if (cnv_cmplt) state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          accum_q <= dst;
          if (ch_q == 3'd5) begin
            state_q <= S_ERR;
          end else begin
            ch_q    <= ch_q + 3'd1;
            state_q <= S_SETTLE;
          end
        end
        S_ERR: begin
          error_q <= dst[11:0];
          state_q <= S_INTG;
        end
        S_INTG: begin
          // Integrator is refreshed only on the last cycle of each decimation period.
          if (int_cnt_q == INT_LAST) intgrl_q <= dst[11:0];
          state_q <= S_ICOMP;
        end
        S_ICOMP: begin
          icomp_q <= dst[11:0];
          state_q <= S_PCOMP;
        end
        S_PCOMP: begin
          pcomp_q <= dst;
          state_q <= S_RHT1;
        end
        S_RHT1: begin
          accum_q <= dst;
          state_q <= S_RHT2;
        end
        S_RHT2: begin
          rht_q   <= dst[11:0];
          state_q <= S_LFT1;
        end
        S_LFT1: begin
          accum_q <= dst;
          state_q <= S_LFT2;
        end
        S_LFT2: begin
          lft_q <= dst[11:0];
          if (int_cnt_q == INT_LAST) int_cnt_q <= '0;
          else                       int_cnt_q <= int_cnt_q + 1'b1;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the ALU control lines; non-ALU states leave them at default.
  always_comb begin
    src1sel  = 3'b000;
    src0sel  = 3'b000;
    multiply = 1'b0;
    sub      = 1'b0;
    mult2    = 1'b0;
    mult4    = 1'b0;
    saturate = 1'b0;
    case (state_q)
      S_ACCUM: begin
        // Odd channels are the left sensors and subtract; outer pairs weigh more.
        sub   = ch_q[0];
        mult2 = (ch_q == 3'd2) || (ch_q == 3'd3);
        mult4 = (ch_q == 3'd4) || (ch_q == 3'd5);
      end
      S_ERR: begin
        src0sel  = 3'b101;
        saturate = 1'b1;
      end
      S_INTG: begin
        src1sel  = 3'b011;
        src0sel  = 3'b001;
        saturate = 1'b1;
      end
      S_ICOMP: begin
        src1sel  = 3'b001;
        src0sel  = 3'b001;
        multiply = 1'b1;
      end
      S_PCOMP: begin
        src1sel  = 3'b010;
        src0sel  = 3'b100;
        multiply = 1'b1;
      end
      S_RHT1: begin
        src1sel = 3'b100;
        src0sel = 3'b011;
        sub     = 1'b1;
      end
      S_RHT2: begin
        src0sel  = 3'b010;
        sub      = 1'b1;
        saturate = 1'b1;
      end
      S_LFT1: begin
        src1sel = 3'b100;
        src0sel = 3'b011;
      end
      S_LFT2: begin
        src0sel  = 3'b010;
        saturate = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign chnnl    = ch_q;
  assign strt_cnv = (state_q == S_CONV);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign Accum    = accum_q;
  assign Pcomp    = pcomp_q;
  assign Error    = error_q;
  assign Intgrl   = intgrl_q;
  assign Icomp    = icomp_q;
  assign rht_reg  = rht_q;
  assign lft_reg  = lft_q;

endmodule
`default_nettype wire

// File: tb/tb_pid_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pid_alu_seq
//  Description : Self-checking bench for pid_alu_seq with an ALU model and
//                an A2D model with programmable completion delay.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pid_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        cnv_cmplt;
  logic [15:0] dst;
  logic [2:0]  chnnl;
  logic        strt_cnv;
  logic [2:0]  src1sel, src0sel;
  logic        multiply, sub, mult2, mult4, saturate;
  logic [15:0] Accum, Pcomp;
  logic [11:0] Error, Intgrl, Icomp, rht_reg, lft_reg;
  logic        busy, done;

  always #5 clk = ~clk;

  pid_alu_seq #(.SETTLE(4), .INT_DEC(4)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .cnv_cmplt(cnv_cmplt), .dst(dst),
    .chnnl(chnnl), .strt_cnv(strt_cnv), .src1sel(src1sel), .src0sel(src0sel),
    .multiply(multiply), .sub(sub), .mult2(mult2), .mult4(mult4), .saturate(saturate),
    .Accum(Accum), .Pcomp(Pcomp), .Error(Error), .Intgrl(Intgrl), .Icomp(Icomp),
    .rht_reg(rht_reg), .lft_reg(lft_reg), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- environment: operands and A2D model ----------------
  logic [11:0] samp_r = 12'h000;
  logic [11:0] samp_l = 12'h000;
  logic [11:0] fwd    = 12'h100;
  logic [11:0] iterm  = 12'h000;
  logic [11:0] pterm  = 12'h000;
  logic [11:0] a2d_res;
  int          a2d_delay = 1;
  int          a2d_pend  = 0;
  logic        cmplt_m   = 1'b0;
  logic        extra     = 1'b0;

  assign a2d_res   = chnnl[0] ? samp_l : samp_r;
  assign cnv_cmplt = cmplt_m | extra;

  always @(posedge clk) begin
    cmplt_m <= 1'b0;
    if (strt_cnv) begin
      if (a2d_delay <= 1) cmplt_m <= 1'b1;
      else                a2d_pend <= a2d_delay - 1;
    end else if (a2d_pend != 0) begin
      a2d_pend <= a2d_pend - 1;
      if (a2d_pend == 1) cmplt_m <= 1'b1;
    end
  end

  // ---------------- ALU model ----------------
  logic [15:0] s1, s0, s0s, sum, prod;
  always_comb begin
    case (src1sel)
      3'b000:  s1 = Accum;
      3'b001:  s1 = {{4{iterm[11]}}, iterm};
      3'b010:  s1 = {{4{Error[11]}}, Error};
      3'b011:  s1 = {{8{Error[11]}}, Error[11:4]};
      3'b100:  s1 = {{4{fwd[11]}}, fwd};
      default: s1 = 16'h0000;
    endcase
    case (src0sel)
      3'b000:  s0 = {4'h0, a2d_res};
      3'b001:  s0 = {{4{Intgrl[11]}}, Intgrl};
      3'b010:  s0 = {{4{Icomp[11]}}, Icomp};
      3'b011:  s0 = Pcomp;
      3'b100:  s0 = {{4{pterm[11]}}, pterm};
      default: s0 = 16'h0000;
    endcase
    s0s  = mult4 ? {s0[13:0], 2'b00} : (mult2 ? {s0[14:0], 1'b0} : s0);
    sum  = sub ? (s1 + ~s0s) : (s1 + s0s);
    prod = s1 * s0;
    if (multiply)                          dst = prod;
    else if (saturate && !sum[15] && sum > 16'h07FF) dst = 16'h07FF;
    else if (saturate &&  sum[15] && sum < 16'hF800) dst = 16'hF800;
    else                                   dst = sum;
  end

  // ---------------- monitor ----------------
  int          strt_cnt = 0, done_cnt = 0, ord_err = 0, stab_err = 0, stable = 0;
  logic [2:0]  last_ch = 3'd0;
  logic [15:0] acc_sweep = 16'hDEAD;

  always @(negedge clk) begin
    if (chnnl == last_ch) stable = stable + 1;
    else                  stable = 1;
    last_ch = chnnl;
    if (strt_cnv) begin
      if (chnnl != strt_cnt[2:0]) ord_err = ord_err + 1;
      if (stable < 5)             stab_err = stab_err + 1;
      strt_cnt = strt_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    if (src0sel == 3'b101 && saturate) acc_sweep = Accum;
  end

  // ---------------- tables ----------------
  typedef struct {
    int         cyc;
    logic [2:0] ch;
    logic       strt;
    logic [2:0] s1;
    logic [2:0] s0;
    logic [4:0] mods;   // {multiply, sub, mult2, mult4, saturate}
  } ctl_t;

  typedef struct {
    bit          rst_first;
    logic [11:0] rs, ls;
    int          dly, x1, x2, g1, g2;
    bit          chk_ctrl;
    int          cyc;
    logic [15:0] acc;
    logic [11:0] err, intg, rht, lft;
  } vec_t;

  ctl_t ctab[16];
  vec_t vtab[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {29'd0, busy, done, strt_cnv}, 32'd0);
    chk({tag, "_ctrl"}, {16'd0, chnnl, src1sel, src0sel, multiply, sub, mult2, mult4, saturate}, 32'd0);
    chk({tag, "_accum_pcomp"}, {Accum, Pcomp}, 32'd0);
    chk({tag, "_err_intg"}, {8'd0, Error, Intgrl}, 32'd0);
    chk({tag, "_icomp"}, {20'd0, Icomp}, 32'd0);
    chk({tag, "_rht_lft"}, {8'd0, rht_reg, lft_reg}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    go    = 1'b0;
    extra = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_ctrl(input int cyc);
    for (int k = 0; k < 16; k++) begin
      if (ctab[k].cyc == cyc) begin
        chk($sformatf("ctrl_cyc%0d", cyc),
            {17'd0, chnnl, strt_cnv, src1sel, src0sel, multiply, sub, mult2, mult4, saturate},
            {17'd0, ctab[k].ch, ctab[k].strt, ctab[k].s1, ctab[k].s0, ctab[k].mods});
      end
    end
  endtask

  // Runs one control cycle; cycle n is the interval after edge n-1, edge 0 samples go.
  task automatic run_cycle(input int g1, input int g2, input int x1, input int x2,
                           input bit chk_c, output int cyc);
    int edges;
    bit got;
    @(negedge clk);
    strt_cnt = 0; done_cnt = 0; ord_err = 0; stab_err = 0; acc_sweep = 16'hDEAD;
    go = 1'b1;
    edges = 0; got = 1'b0; cyc = 0;
    while (!got && edges < 400) begin
      @(posedge clk);
      edges = edges + 1;
      @(negedge clk);
      go    = (edges == g1) || (edges == g2);
      extra = (edges == x1) || (edges == x2);
      if (chk_c) check_ctrl(edges);
      if (done) begin
        got = 1'b1;
        cyc = edges;
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
    go = 1'b0;
    extra = 1'b0;
    chk("done_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("strt_pulses", strt_cnt, 6);
    chk("chnnl_order", ord_err, 0);
    chk("chnnl_settle", stab_err, 0);
    chk("done_count", done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Expected control lines at fixed cycles of a SETTLE=4, W=1 run.
    ctab[0]  = '{3,  3'd0, 1'b0, 3'b000, 3'b000, 5'b00000};
    ctab[1]  = '{5,  3'd0, 1'b1, 3'b000, 3'b000, 5'b00000};
    ctab[2]  = '{7,  3'd0, 1'b0, 3'b000, 3'b000, 5'b00000};
    ctab[3]  = '{14, 3'd1, 1'b0, 3'b000, 3'b000, 5'b01000};
    ctab[4]  = '{21, 3'd2, 1'b0, 3'b000, 3'b000, 5'b00100};
    ctab[5]  = '{28, 3'd3, 1'b0, 3'b000, 3'b000, 5'b01100};
    ctab[6]  = '{35, 3'd4, 1'b0, 3'b000, 3'b000, 5'b00010};
    ctab[7]  = '{42, 3'd5, 1'b0, 3'b000, 3'b000, 5'b01010};
    ctab[8]  = '{43, 3'd5, 1'b0, 3'b000, 3'b101, 5'b00001};
    ctab[9]  = '{44, 3'd5, 1'b0, 3'b011, 3'b001, 5'b00001};
    ctab[10] = '{45, 3'd5, 1'b0, 3'b001, 3'b001, 5'b10000};
    ctab[11] = '{46, 3'd5, 1'b0, 3'b010, 3'b100, 5'b10000};
    ctab[12] = '{47, 3'd5, 1'b0, 3'b100, 3'b011, 5'b01000};
    ctab[13] = '{48, 3'd5, 1'b0, 3'b000, 3'b010, 5'b01001};
    ctab[14] = '{49, 3'd5, 1'b0, 3'b100, 3'b011, 5'b00000};
    ctab[15] = '{50, 3'd5, 1'b0, 3'b000, 3'b010, 5'b00001};

    //            rst  right    left     dly x1 x2 g1 g2  ctl cyc  acc       err      intg     rht      lft
    vtab[0]  = '{1'b1, 12'h100, 12'h100, 1,  0, 0, 0, 0,  1'b1, 51,  16'hFFFD, 12'hFFD, 12'h000, 12'h0FE, 12'h100};
    vtab[1]  = '{1'b0, 12'h100, 12'h100, 10, 2, 5, 0, 0,  1'b0, 105, 16'hFFFD, 12'hFFD, 12'h000, 12'h0FE, 12'h100};
    vtab[2]  = '{1'b0, 12'h100, 12'h100, 1,  0, 0, 7, 47, 1'b0, 51,  16'hFFFD, 12'hFFD, 12'h000, 12'h0FE, 12'h100};
    vtab[3]  = '{1'b1, 12'hFFF, 12'h000, 1,  0, 0, 0, 0,  1'b0, 51,  16'h6FF6, 12'h7FF, 12'h000, 12'h0FE, 12'h100};
    vtab[4]  = '{1'b0, 12'hFFF, 12'h000, 1,  0, 0, 0, 0,  1'b0, 51,  16'h6FF6, 12'h7FF, 12'h000, 12'h0FE, 12'h100};
    vtab[5]  = '{1'b0, 12'hFFF, 12'h000, 1,  0, 0, 0, 0,  1'b0, 51,  16'h6FF6, 12'h7FF, 12'h000, 12'h0FE, 12'h100};
    vtab[6]  = '{1'b0, 12'hFFF, 12'h000, 1,  0, 0, 0, 0,  1'b0, 51,  16'h6FF6, 12'h7FF, 12'h07F, 12'h0FE, 12'h100};
    vtab[7]  = '{1'b0, 12'hFFF, 12'h000, 1,  0, 0, 0, 0,  1'b0, 51,  16'h6FF6, 12'h7FF, 12'h07F, 12'h0FE, 12'h100};
    vtab[8]  = '{1'b0, 12'hFFF, 12'h000, 1,  0, 0, 0, 0,  1'b0, 51,  16'h6FF6, 12'h7FF, 12'h07F, 12'h0FE, 12'h100};
    vtab[9]  = '{1'b0, 12'hFFF, 12'h000, 1,  0, 0, 0, 0,  1'b0, 51,  16'h6FF6, 12'h7FF, 12'h07F, 12'h0FE, 12'h100};
    vtab[10] = '{1'b0, 12'hFFF, 12'h000, 1,  0, 0, 0, 0,  1'b0, 51,  16'h6FF6, 12'h7FF, 12'h0FE, 12'h0FE, 12'h100};

    rst_n = 1'b1;
    go    = 1'b0;
    #3;

    for (int v = 0; v < 11; v++) begin
      if (vtab[v].rst_first) do_reset();
      samp_r    = vtab[v].rs;
      samp_l    = vtab[v].ls;
      a2d_delay = vtab[v].dly;
      run_cycle(vtab[v].g1, vtab[v].g2, vtab[v].x1, vtab[v].x2, vtab[v].chk_ctrl, cyc);
      chk($sformatf("v%0d_done_cycle", v), cyc, vtab[v].cyc);
      chk($sformatf("v%0d_accum_sweep", v), {16'd0, acc_sweep}, {16'd0, vtab[v].acc});
      chk($sformatf("v%0d_error", v), {20'd0, Error}, {20'd0, vtab[v].err});
      chk($sformatf("v%0d_intgrl", v), {20'd0, Intgrl}, {20'd0, vtab[v].intg});
      chk($sformatf("v%0d_pcomp_icomp", v), {4'd0, Icomp, Pcomp}, 32'd0);
      chk($sformatf("v%0d_accum_final", v), {16'd0, Accum}, 32'h0000_0100);
      chk($sformatf("v%0d_rht", v), {20'd0, rht_reg}, {20'd0, vtab[v].rht});
      chk($sformatf("v%0d_lft", v), {20'd0, lft_reg}, {20'd0, vtab[v].lft});
    end

    // Reset asserted during WAIT of channel 3 (cycle 27 with W=1).
    samp_r    = 12'hFFF;
    samp_l    = 12'h000;
    a2d_delay = 1;
    @(negedge clk);
    go = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      @(posedge clk);
      @(negedge clk);
      go = 1'b0;
    end
    chk("mid_chnnl_before_rst", {29'd0, chnnl}, 32'd3);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_idle_after_rst", {31'd0, busy}, 32'd0);
    run_cycle(0, 0, 0, 0, 1'b0, cyc);
    chk("post_rst_done_cycle", cyc, 51);
    chk("post_rst_accum_sweep", {16'd0, acc_sweep}, 32'h0000_6FF6);
    chk("post_rst_error", {20'd0, Error}, 32'h0000_07FF);
    chk("post_rst_intgrl", {20'd0, Intgrl}, 32'd0);
    chk("post_rst_rht_lft", {8'd0, rht_reg, lft_reg}, {8'd0, 12'h0FE, 12'h100});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
